// File: rtl/control_unit.sv
// Multicycle fetch/decode/execute sequencer for the single-bus ezRISC datapath.
// Build option: define MULDIV_EN to add mul (op 15) / div (op 16) with an alu_done handshake.
module control_unit #(
  parameter int REG_SIZE = 32,
  parameter int NUM_GP   = 16,
  parameter int WAIT_MAX = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_SIZE-1:0] ir,
  input  logic                con_ff,
  input  logic                mem_ready,
  input  logic                alu_done,
  output logic [NUM_GP-1:0]   gp_le,
  output logic [NUM_GP-1:0]   gp_out,
  output logic                pc_le,
  output logic                pc_out,
  output logic                ir_le,
  output logic                y_le,
  output logic                z_le,
  output logic                z_out,
  output logic                z_hi_out,
  output logic                z_lo_out,
  output logic                mar_le,
  output logic                hi_le,
  output logic                lo_le,
  output logic                mdr_in,
  output logic                md_mux_select,
  output logic                mdr_out,
  output logic                c_out,
  output logic                con_le,
  output logic [3:0]          alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic                run,
  output logic                fault
);
  // state | meaning
  // RST   | in/just out of reset, all strobes low
  // T0-T2 | fetch: PC->MAR/Z=PC+1, PC update + read, MDR->IR (T1W waits on memory)
  // DEC   | decode cycle, no strobes
  // T3-T7 | execute steps of the decoded class
  // HALT  | halt instruction or wait timeout; left only by reset
  typedef enum logic [3:0] {S_RST, S_T0, S_T1, S_T1W, S_T2, S_DEC, S_T3, S_T4, S_T5, S_T6,
                            S_T7, S_HALT} state_t;
  typedef enum logic [2:0] {C_NOP, C_ALU, C_ADDI, C_LD, C_ST, C_BR, C_MD, C_HALT} class_t;

  typedef struct packed {
    logic [NUM_GP-1:0] gp_le;
    logic [NUM_GP-1:0] gp_out;
    logic pc_le, pc_out, ir_le, y_le, z_le, z_out, z_hi_out, z_lo_out;
    logic mar_le, hi_le, lo_le, mdr_in, md_mux_select, mdr_out, c_out, con_le;
    logic [3:0] alu_op;
    logic mem_read, mem_write;
  } strobe_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_MUL = 4'd4, ALU_DIV = 4'd5, ALU_INC = 4'd6;
  localparam logic [NUM_GP-1:0] GP_ONE = 1;

  state_t    r_state, w_next;
  class_t    w_cls;
  strobe_t   r_s;
  logic [7:0] r_wait;
  logic      r_run, r_fault;
  logic      w_in_wait, w_ready, w_timeout, w_rd_ack, w_md_ack, w_unused;

  logic [4:0] w_op;
  logic [3:0] w_ra, w_rb, w_rc;
  assign w_op = ir[31:27];
  assign w_ra = ir[26:23];
  assign w_rb = ir[22:19];
  assign w_rc = ir[18:15];
  assign w_unused = ^{ir[14:0], alu_done};

  always_comb begin
    w_cls = C_NOP;
    case (w_op)
      5'd3, 5'd4, 5'd5, 5'd6: w_cls = C_ALU;
      5'd12:                  w_cls = C_ADDI;
      5'd0:                   w_cls = C_LD;
      5'd1:                   w_cls = C_ST;
      5'd18:                  w_cls = C_BR;
      5'd27:                  w_cls = C_HALT;
`ifdef MULDIV_EN
      5'd15, 5'd16:           w_cls = C_MD;
`endif
      default:                w_cls = C_NOP;
    endcase
  end

  assign w_in_wait = (r_state == S_T1W) || (r_state == S_T6 && w_cls == C_LD) ||
                     (r_state == S_T7 && w_cls == C_ST) || (r_state == S_T4 && w_cls == C_MD);
  assign w_ready   = (r_state == S_T4 && w_cls == C_MD) ? alu_done : mem_ready;
  // ready on the last allowed wait cycle still wins over the timeout
  assign w_timeout = w_in_wait && !w_ready && (r_wait == 8'(WAIT_MAX - 1));
  assign w_rd_ack  = mem_ready && ((r_state == S_T1W) || (r_state == S_T6 && w_cls == C_LD));
  assign w_md_ack  = alu_done && (r_state == S_T4) && (w_cls == C_MD);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:  w_next = S_T0;
      S_T0:   w_next = S_T1;
      S_T1:   w_next = S_T1W;
      S_T1W:  w_next = S_T2;
      S_T2:   w_next = S_DEC;
      S_DEC:  w_next = (w_cls == C_NOP) ? S_T0 : (w_cls == C_HALT) ? S_HALT : S_T3;
      S_T3:   w_next = S_T4;
      S_T4:   w_next = S_T5;
      S_T5:   w_next = (w_cls == C_ALU || w_cls == C_ADDI) ? S_T0 : S_T6;
      S_T6:   w_next = (w_cls == C_LD || w_cls == C_ST) ? S_T7 : S_T0;
      S_T7:   w_next = S_T0;
      S_HALT: w_next = S_HALT;
      default: w_next = S_RST;
    endcase
    if (w_in_wait && !w_ready) w_next = w_timeout ? S_HALT : r_state;
  end

  function automatic strobe_t strobes(state_t st, class_t cl, logic [4:0] op,
                                      logic [3:0] ra, logic [3:0] rb, logic [3:0] rc, logic cff);
    strobe_t s;
    s = '0;
    case (st)
      S_T0:  begin s.pc_out = 1'b1; s.mar_le = 1'b1; s.alu_op = ALU_INC; s.z_le = 1'b1; end
      S_T1:  begin s.z_out = 1'b1; s.pc_le = 1'b1; s.mem_read = 1'b1; end
      S_T1W: s.mem_read = 1'b1;
      S_T2:  begin s.mdr_out = 1'b1; s.ir_le = 1'b1; end
      S_T3: begin
        if (cl == C_BR)      begin s.gp_out = GP_ONE << ra; s.con_le = 1'b1; end
        else if (cl == C_MD) begin s.gp_out = GP_ONE << ra; s.y_le = 1'b1; end
        else                 begin s.gp_out = GP_ONE << rb; s.y_le = 1'b1; end
      end
      S_T4: begin
        if (cl == C_ALU)     begin s.gp_out = GP_ONE << rc; s.alu_op = 4'(op - 5'd3); s.z_le = 1'b1; end
        else if (cl == C_BR) begin s.pc_out = 1'b1; s.y_le = 1'b1; end
        else if (cl == C_MD) begin s.gp_out = GP_ONE << rb; s.alu_op = (op == 5'd15) ? ALU_MUL : ALU_DIV; end
        else                 begin s.c_out = 1'b1; s.alu_op = ALU_ADD; s.z_le = 1'b1; end
      end
      S_T5: begin
        if (cl == C_ALU || cl == C_ADDI) begin s.z_out = 1'b1; s.gp_le = GP_ONE << ra; end
        else if (cl == C_BR)             begin s.c_out = 1'b1; s.alu_op = ALU_ADD; s.z_le = 1'b1; end
        else if (cl == C_MD)             begin s.z_lo_out = 1'b1; s.lo_le = 1'b1; end
        else                             begin s.z_out = 1'b1; s.mar_le = 1'b1; end
      end
      S_T6: begin
        if (cl == C_LD)      s.mem_read = 1'b1;
        else if (cl == C_ST) begin s.gp_out = GP_ONE << ra; s.mdr_in = 1'b1; end
        else if (cl == C_MD) begin s.z_hi_out = 1'b1; s.hi_le = 1'b1; end
        else if (cff)        begin s.z_out = 1'b1; s.pc_le = 1'b1; end
      end
      S_T7: begin
        if (cl == C_LD) begin s.mdr_out = 1'b1; s.gp_le = GP_ONE << ra; end
        else            s.mem_write = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RST;
      r_wait  <= '0;
      r_s     <= '0;
      r_run   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= (w_in_wait && !w_ready) ? r_wait + 8'd1 : 8'd0;
      r_s     <= strobes(w_next, w_cls, w_op, w_ra, w_rb, w_rc, con_ff);
      r_run   <= (w_next != S_RST) && (w_next != S_HALT);
      r_fault <= r_fault | w_timeout;
    end
  end

  // memory-read and MUL/DIV completions load in the same cycle ready is seen
  assign mdr_in        = r_s.mdr_in | w_rd_ack;
  assign md_mux_select = r_s.md_mux_select | w_rd_ack;
  assign z_le          = r_s.z_le | w_md_ack;
  assign gp_le     = r_s.gp_le;
  assign gp_out    = r_s.gp_out;
  assign pc_le     = r_s.pc_le;
  assign pc_out    = r_s.pc_out;
  assign ir_le     = r_s.ir_le;
  assign y_le      = r_s.y_le;
  assign z_out     = r_s.z_out;
  assign z_hi_out  = r_s.z_hi_out;
  assign z_lo_out  = r_s.z_lo_out;
  assign mar_le    = r_s.mar_le;
  assign hi_le     = r_s.hi_le;
  assign lo_le     = r_s.lo_le;
  assign mdr_out   = r_s.mdr_out;
  assign c_out     = r_s.c_out;
  assign con_le    = r_s.con_le;
  assign alu_op    = r_s.alu_op;
  assign mem_read  = r_s.mem_read;
  assign mem_write = r_s.mem_write;
  assign run       = r_run;
  assign fault     = r_fault;
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction-level procedural model of the expected strobes per cycle,
// randomized instructions and ready timing, plus directed literal checks.
`timescale 1ns/1ps
module tb_control_unit;
  typedef struct packed {
    logic run, fault;
    logic [15:0] gp_le, gp_out;
    logic pc_le, pc_out, ir_le, y_le, z_le, z_out, z_hi_out, z_lo_out;
    logic mar_le, hi_le, lo_le, mdr_in, md_mux_select, mdr_out, c_out, con_le;
    logic [3:0] alu_op;
    logic mem_read, mem_write;
  } exp_t;

  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] ir = '0;
  logic con_ff = 1'b0, mem_ready = 1'b0, alu_done = 1'b0;
  logic [15:0] gp_le, gp_out;
  logic pc_le, pc_out, ir_le, y_le, z_le, z_out, z_hi_out, z_lo_out, mar_le, hi_le, lo_le;
  logic mdr_in, md_mux_select, mdr_out, c_out, con_le, mem_read, mem_write, run, fault;
  logic [3:0] alu_op;

  control_unit dut (
    .clk(clk), .reset(rst), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready), .alu_done(alu_done),
    .gp_le(gp_le), .gp_out(gp_out), .pc_le(pc_le), .pc_out(pc_out), .ir_le(ir_le), .y_le(y_le),
    .z_le(z_le), .z_out(z_out), .z_hi_out(z_hi_out), .z_lo_out(z_lo_out), .mar_le(mar_le),
    .hi_le(hi_le), .lo_le(lo_le), .mdr_in(mdr_in), .md_mux_select(md_mux_select),
    .mdr_out(mdr_out), .c_out(c_out), .con_le(con_le), .alu_op(alu_op), .mem_read(mem_read),
    .mem_write(mem_write), .run(run), .fault(fault)
  );

  always #5 clk = ~clk;

  exp_t act, expv;
  assign act = {run, fault, gp_le, gp_out, pc_le, pc_out, ir_le, y_le, z_le, z_out, z_hi_out,
                z_lo_out, mar_le, hi_le, lo_le, mdr_in, md_mux_select, mdr_out, c_out, con_le,
                alu_op, mem_read, mem_write};

  int n_cmp = 0, n_bad = 0;
  logic chk = 1'b0;
  int cyc_cnt = 0, n_step = 0, t0_cyc = 0, gp_cyc = -1;
  logic [15:0] gp_seen = '0;
  int n_mr = 0, n_pcle = 0, n_mdrin = 0, n_lo = 0, n_hi = 0;
  int fd_mem = -1, fd_alu = -1, abort_at = -1;
  bit tied = 0, aborted = 0, need_reset = 0;
  int ops[11] = '{0, 1, 3, 4, 5, 6, 12, 15, 16, 18, 26};

  always @(negedge clk) begin
    if (chk) begin
      n_cmp++;
      if (act !== expv) begin
        n_bad++;
        $display("FAIL cycle_outputs @%0d step %0d: got %h want %h", cyc_cnt, n_step, act, expv);
      end
      n_cmp++;
      if ($countones({gp_out, pc_out, z_out, z_hi_out, z_lo_out, mdr_out, c_out}) > 1 ||
          $countones(gp_le) > 1) begin
        n_bad++;
        $display("FAIL bus_onehot @%0d: got gp_out=%h gp_le=%h want at most one driver", cyc_cnt, gp_out, gp_le);
      end
      if (gp_le != 0) begin gp_seen = gp_le; gp_cyc = cyc_cnt; end
      if (mem_read) n_mr++;
      if (pc_le) n_pcle++;
      if (mdr_in) n_mdrin++;
      if (lo_le) n_lo++;
      if (hi_le) n_hi++;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic exp_t live();
    exp_t e = '0;
    e.run = 1'b1;
    return e;
  endfunction

  function automatic exp_t halted(input bit f);
    exp_t e = '0;
    e.fault = f;
    return e;
  endfunction

  task automatic step_raw(input exp_t e);
    if (aborted) return;
    expv = e;
    chk = 1'b1;
    if (abort_at >= 0 && n_step == abort_at) begin
      #2;
      check("pre_abort_strobes", 64'(act), 64'(e));
      chk = 1'b0;
      rst = 1'b1;
      #1;
      check("abort_outputs_zero", 64'(act), 64'd0);
      aborted = 1;
      abort_at = -1;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    n_step++;
    cyc_cnt++;
  endtask

  task automatic step(input exp_t e);
    mem_ready = tied ? 1'b1 : 1'($urandom);
    alu_done  = tied ? 1'b1 : 1'($urandom);
    step_raw(e);
  endtask

  // kind 0: memory read, 1: memory write, 2: MUL/DIV
  task automatic wait_ph(input exp_t base, input int kind, output bit to);
    int d;
    bit r;
    exp_t e;
    to = 0;
    d = (kind == 2) ? fd_alu : fd_mem;
    if (d < 0) d = $urandom_range(0, 5);
    for (int k = 0; k < 255; k++) begin
      r = (k >= d);
      if (kind == 2) begin alu_done = r; mem_ready = 1'($urandom); end
      else begin mem_ready = r; alu_done = 1'($urandom); end
      e = base;
      if (r && kind == 0) begin e.mdr_in = 1'b1; e.md_mux_select = 1'b1; end
      if (r && kind == 2) e.z_le = 1'b1;
      step_raw(e);
      if (r || aborted) return;
    end
    to = 1;
  endtask

  task automatic fault_tail();
    need_reset = 1;
    repeat (4) step(halted(1));
  endtask

  task automatic do_reset();
    chk = 1'b0;
    rst = 1'b1;
    mem_ready = 1'b0;
    alu_done = 1'b0;
    #1;
    check("reset_outputs_zero", 64'(act), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    aborted = 0;
    need_reset = 0;
    n_step = 0;
    step_raw(halted(0));
  endtask

  task automatic run_instr(input logic [31:0] w, input logic con);
    exp_t e;
    bit to;
    logic [4:0] op;
    logic [15:0] ra1, rb1, rc1;
    op = w[31:27];
    ra1 = 16'd1 << w[26:23];
    rb1 = 16'd1 << w[22:19];
    rc1 = 16'd1 << w[18:15];
    ir = w; con_ff = con;
    n_step = 0; t0_cyc = cyc_cnt; gp_seen = '0; gp_cyc = -1;
    n_mr = 0; n_pcle = 0; n_mdrin = 0; n_lo = 0; n_hi = 0;
    e = live(); e.pc_out = 1; e.mar_le = 1; e.alu_op = 4'd6; e.z_le = 1; step(e);
    e = live(); e.z_out = 1; e.pc_le = 1; e.mem_read = 1; step(e);
    e = live(); e.mem_read = 1; wait_ph(e, 0, to);
    if (to) begin fault_tail(); return; end
    e = live(); e.mdr_out = 1; e.ir_le = 1; step(e);
    step(live());
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd12: begin
        e = live(); e.gp_out = rb1; e.y_le = 1; step(e);
        e = live(); e.z_le = 1;
        if (op == 5'd12) e.c_out = 1;
        else begin e.gp_out = rc1; e.alu_op = 4'(op - 5'd3); end
        step(e);
        e = live(); e.z_out = 1; e.gp_le = ra1; step(e);
      end
      5'd0, 5'd1: begin
        e = live(); e.gp_out = rb1; e.y_le = 1; step(e);
        e = live(); e.c_out = 1; e.z_le = 1; step(e);
        e = live(); e.z_out = 1; e.mar_le = 1; step(e);
        if (op == 5'd0) begin
          e = live(); e.mem_read = 1; wait_ph(e, 0, to);
          if (to) begin fault_tail(); return; end
          e = live(); e.mdr_out = 1; e.gp_le = ra1; step(e);
        end else begin
          e = live(); e.gp_out = ra1; e.mdr_in = 1; step(e);
          e = live(); e.mem_write = 1; wait_ph(e, 1, to);
          if (to) begin fault_tail(); return; end
        end
      end
      5'd18: begin
        e = live(); e.gp_out = ra1; e.con_le = 1; step(e);
        e = live(); e.pc_out = 1; e.y_le = 1; step(e);
        e = live(); e.c_out = 1; e.z_le = 1; step(e);
        e = live(); if (con) begin e.z_out = 1; e.pc_le = 1; end step(e);
      end
`ifdef MULDIV_EN
      5'd15, 5'd16: begin
        e = live(); e.gp_out = ra1; e.y_le = 1; step(e);
        e = live(); e.gp_out = rb1; e.alu_op = (op == 5'd15) ? 4'd4 : 4'd5; wait_ph(e, 2, to);
        if (to) begin fault_tail(); return; end
        e = live(); e.z_lo_out = 1; e.lo_le = 1; step(e);
        e = live(); e.z_hi_out = 1; e.hi_le = 1; step(e);
      end
`endif
      5'd27: begin
        need_reset = 1;
        repeat (3) step(halted(0));
      end
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [4:0] op;
    @(posedge clk); #1;
    do_reset();

    // add R3,R1,R2 with memory always ready
    tied = 1; fd_mem = 0;
    run_instr({5'd3, 4'd3, 4'd1, 4'd2, 15'd0}, 1'b0);
    check("add_gp_le", 64'(gp_seen), 64'h0008);
    check("add_write_offset", 64'(gp_cyc - t0_cyc), 64'd7);
    tied = 0;

    // reset in the middle of T4 of an add
    abort_at = 6;
    run_instr({5'd3, 4'd3, 4'd1, 4'd2, 15'd0}, 1'b0);
    check("abort_no_write", 64'(gp_seen), 64'h0000);
    do_reset();
    run_instr({5'd4, 4'd7, 4'd1, 4'd2, 15'd0}, 1'b0);
    check("post_abort_sub_gp_le", 64'(gp_seen), 64'h0080);

    // ld R2,0x10(R1) with memory three cycles late
    fd_mem = 3;
    run_instr({5'd0, 4'd2, 4'd1, 19'h10}, 1'b0);
    check("ld_gp_le", 64'(gp_seen), 64'h0004);
    check("ld_mem_read_cycles", 64'(n_mr), 64'd9);
    check("ld_mdr_in_cycles", 64'(n_mdrin), 64'd2);
    fd_mem = 0;

    // br C=-2 taken and not taken
    run_instr({5'd18, 4'd5, 4'd0, 19'h7FFFE}, 1'b1);
    check("br_taken_pc_le", 64'(n_pcle), 64'd2);
    run_instr({5'd18, 4'd5, 4'd0, 19'h7FFFE}, 1'b0);
    check("br_not_taken_pc_le", 64'(n_pcle), 64'd1);

    // mul R4,R5 with alu_done after 10 cycles
    fd_alu = 10;
    run_instr({5'd15, 4'd4, 4'd5, 19'd0}, 1'b0);
`ifdef MULDIV_EN
    check("mul_lo_le", 64'(n_lo), 64'd1);
    check("mul_hi_le", 64'(n_hi), 64'd1);
    check("mul_cycles", 64'(n_step), 64'd19);
`else
    check("mul_as_nop_lo_hi", 64'(n_lo + n_hi), 64'd0);
    check("mul_as_nop_cycles", 64'(n_step), 64'd5);
`endif
    fd_alu = -1; fd_mem = -1;

    for (int i = 0; i < 200; i++) begin
      w = $urandom;
      op = 5'(ops[$urandom_range(0, 10)]);
      if ($urandom_range(0, 24) == 0) op = 5'd27;
      if ($urandom_range(0, 9) == 0) op = 5'($urandom);
      w[31:27] = op;
      run_instr(w, 1'($urandom));
      if (need_reset) do_reset();
    end

    // memory never answers during fetch
    fd_mem = 1000;
    run_instr({5'd3, 4'd1, 4'd2, 4'd3, 15'd0}, 1'b0);
    check("timeout_mem_read_cycles", 64'(n_mr), 64'd256);
    check("timeout_fault_sticky", 64'(fault), 64'd1);
    check("timeout_run_low", 64'(run), 64'd0);
    fd_mem = -1;
    do_reset();
    run_instr({5'd26, 27'd0}, 1'b0);

    chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
